// File: rtl/cache_inval_ctrl.sv
// cache_inval_ctrl: cache maintenance sequencer that stalls the cache,
// waits for it to drain, then clears tag-RAM valid bits (one line or all).
//
// Ports:
//   i_hclk        clock, all state on the rising edge
//   i_hreset      asynchronous active-high reset
//   i_start       single-cycle command strobe
//   i_mode        0 = invalidate all lines, 1 = invalidate one line
//   i_index       line index for single mode, sampled with i_start
//   i_cache_idle  cache has no fill / AHB transfer outstanding
//   i_tag_gnt     tag RAM accepts the write presented this cycle
//   o_cache_hold  holds the cache slave off new transfers
//   o_tag_we      tag-RAM valid-clear write request
//   o_tag_idx     line index being cleared
//   o_busy        command in progress (drain or clear)
//   o_done        one-cycle completion pulse
//   o_overrun     sticky: i_start seen while a command was in flight
module cache_inval_ctrl #(
    parameter int LINES = 256,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             i_hclk,
    input  logic             i_hreset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_cache_idle,
    input  logic             i_tag_gnt,
    output logic             o_cache_hold,
    output logic             o_tag_we,
    output logic [IDX_W-1:0] o_tag_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINES - 1);

    state_t           state;
    logic             single;
    logic [IDX_W-1:0] cnt;

    // The counter register drives the index directly, so the index is
    // glitch-free and only moves when a write has been accepted.
    assign o_tag_idx = cnt;

    // Every output flop is loaded with the value belonging to the state
    // being entered, so outputs line up with the state register exactly.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state        <= IDLE;
            single       <= 1'b0;
            cnt          <= '0;
            o_cache_hold <= 1'b0;
            o_tag_we     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        single       <= i_mode;
                        cnt          <= i_mode ? i_index : '0;
                        o_overrun    <= 1'b0;
                        o_cache_hold <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_start) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_cache_idle) begin
                        o_tag_we <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (i_start) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_tag_gnt) begin
                        // Counter stops at the last line; it never wraps.
                        if (single || cnt == LAST) begin
                            o_tag_we     <= 1'b0;
                            o_cache_hold <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (i_start) begin
                        o_overrun <= 1'b1;
                    end
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_cache_hold <= 1'b0;
                    o_tag_we     <= 1'b0;
                    o_busy       <= 1'b0;
                    o_done       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
